// File: rtl/snake_playfield.sv
// snake_playfield: snake game rendered on a row of 7-segment digits.
// The playfield is a vertex grid (columns 0..NUM_DIGITS, rows 0..2). The snake
// is a chain of length+1 vertices, and every edge between consecutive vertices
// lights one segment (or a shared pair of segments on adjacent digits).
//
// Ports:
//   clk        single clock
//   rst        asynchronous active-high reset
//   start      single-cycle start (IDLE) / restart (OVER) request
//   dir_req    requested heading: 00 right, 01 up, 10 left, 11 down
//   dir_load   strobe qualifying dir_req
//   seg_n      active-low segments, digit d at [7d+6:7d] as a..g from bit 0
//   game_over  high while the game is over
//   length     current snake length in edges
module snake_playfield #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 33554432,
  parameter int GROW_EVERY = 8,
  parameter int MAX_LEN    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     dir_req,
  input  logic                           dir_load,
  output logic [7*NUM_DIGITS-1:0]        seg_n,
  output logic                           game_over,
  output logic [$clog2(MAX_LEN+1)-1:0]   length
);

  localparam int SW = 7 * NUM_DIGITS;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int XW = $clog2(NUM_DIGITS + 2) + 1;  // signed: covers -1..NUM_DIGITS+1
  localparam int YW = 3;                           // signed: covers -1..3
  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(GROW_EVERY + 1);
  localparam int unsigned NV = MAX_LEN + 1;        // vertex storage

  typedef logic signed [XW-1:0] xc_t;
  typedef logic signed [YW-1:0] yc_t;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam xc_t X0   = xc_t'(0);
  localparam xc_t XMAX = xc_t'(NUM_DIGITS);
  localparam yc_t Y0   = yc_t'(0);
  localparam yc_t Y1   = yc_t'(1);
  localparam yc_t Y2   = yc_t'(2);
  localparam logic [SW-1:0] SEG_INIT = ~((SW'(1) << 6) | (SW'(1) << 13));

  function automatic xc_t init_x(input int unsigned i);
    return (i < 3) ? xc_t'(2 - int'(i)) : X0;
  endfunction

  state_t          state, state_nx;
  logic [TW-1:0]   cnt;
  logic            tick;
  xc_t             vx    [NV];
  yc_t             vy    [NV];
  xc_t             vx_nx [NV];
  yc_t             vy_nx [NV];
  logic [LW-1:0]   len, len_nx;
  logic [MW-1:0]   mc, mc_nx, mc_inc;
  logic [1:0]      heading, head_nx, pending, pend_nx;
  logic            blank, blank_nx;
  xc_t             step_x;
  yc_t             step_y;
  logic            wrap, grow, hit;
  logic [SW-1:0]   lit;
  xc_t             ax, bx, col, lo_x;
  yc_t             ay, by, top;

  assign tick   = (cnt == TW'(TICK_DIV - 1));
  assign length = len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Candidate move and collision test, evaluated every cycle.
  always_comb begin
    step_x = vx[0];
    step_y = vy[0];
    unique case (pending)
      2'b00:   step_x = vx[0] + xc_t'(1);
      2'b01:   step_y = vy[0] - yc_t'(1);
      2'b10:   step_x = vx[0] - xc_t'(1);
      default: step_y = vy[0] + yc_t'(1);
    endcase
    mc_inc = mc + 1'b1;
    wrap   = (mc_inc == MW'(GROW_EVERY));
    grow   = wrap && (len < LW'(MAX_LEN));
    hit    = (step_x < X0) || (step_x > XMAX) || (step_y < Y0) || (step_y > Y2);
    // Body check covers v0..v(len-1); the tail only counts when it stays put.
    for (int unsigned i = 0; i < NV; i++) begin
      if (((LW'(i) < len) || ((LW'(i) == len) && grow)) &&
          (vx[i] == step_x) && (vy[i] == step_y))
        hit = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    len_nx   = len;
    mc_nx    = mc;
    head_nx  = heading;
    pend_nx  = pending;
    blank_nx = blank;
    for (int unsigned i = 0; i < NV; i++) begin
      vx_nx[i] = vx[i];
      vy_nx[i] = vy[i];
    end
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (tick) begin
          head_nx = pending;
          if (hit) begin
            state_nx = OVER;
            blank_nx = 1'b0;
          end else begin
            for (int unsigned i = 1; i < NV; i++) begin
              vx_nx[i] = vx[i-1];
              vy_nx[i] = vy[i-1];
            end
            vx_nx[0] = step_x;
            vy_nx[0] = step_y;
            if (grow) len_nx = len + 1'b1;
            mc_nx = wrap ? '0 : mc_inc;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_nx = IDLE;
          len_nx   = LW'(2);
          mc_nx    = '0;
          head_nx  = 2'b00;
          pend_nx  = 2'b00;
          blank_nx = 1'b0;
          for (int unsigned i = 0; i < NV; i++) begin
            vx_nx[i] = init_x(i);
            vy_nx[i] = Y1;
          end
        end else if (tick) begin
          blank_nx = ~blank;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reversal is judged against the committed heading; a load coinciding
    // with a tick lands in pending after the move has used the old value.
    if (dir_load && (state != OVER) && (dir_req != (heading ^ 2'b10)))
      pend_nx = dir_req;
  end

  // Segment map of the next chain so seg_n lands on the same edge as the move.
  always_comb begin
    lit  = '0;
    ax   = X0;
    bx   = X0;
    ay   = Y0;
    by   = Y0;
    col  = X0;
    lo_x = X0;
    top  = Y0;
    for (int unsigned e = 0; e < NV - 1; e++) begin
      if (LW'(e) < len_nx) begin
        ax   = vx_nx[e];
        bx   = vx_nx[e+1];
        ay   = vy_nx[e];
        by   = vy_nx[e+1];
        lo_x = (ax < bx) ? ax : bx;
        top  = (ay < by) ? ay : by;
        col  = ax;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
          if (ay == by) begin
            if (lo_x == xc_t'(d)) begin
              if (ay == Y0)      lit[7*d+0] = 1'b1;
              else if (ay == Y1) lit[7*d+6] = 1'b1;
              else               lit[7*d+3] = 1'b1;
            end
          end else begin
            if (col == xc_t'(d)) begin
              if (top == Y0) lit[7*d+5] = 1'b1;
              else           lit[7*d+4] = 1'b1;
            end
            if (col == xc_t'(d + 1)) begin
              if (top == Y0) lit[7*d+1] = 1'b1;
              else           lit[7*d+2] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= LW'(2);
      mc        <= '0;
      heading   <= 2'b00;
      pending   <= 2'b00;
      blank     <= 1'b0;
      seg_n     <= SEG_INIT;
      game_over <= 1'b0;
      for (int unsigned i = 0; i < NV; i++) begin
        vx[i] <= init_x(i);
        vy[i] <= Y1;
      end
    end else begin
      state     <= state_nx;
      len       <= len_nx;
      mc        <= mc_nx;
      heading   <= head_nx;
      pending   <= pend_nx;
      blank     <= blank_nx;
      seg_n     <= blank_nx ? '1 : ~lit;
      game_over <= (state_nx == OVER);
      for (int unsigned i = 0; i < NV; i++) begin
        vx[i] <= vx_nx[i];
        vy[i] <= vy_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_snake_playfield.sv
// Bench for snake_playfield: two instances (GROW_EVERY 4 and 1) share one
// stimulus stream; a game-level model predicts every output each cycle and
// directed scenarios pin hand-computed values.
module tb_snake_playfield;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dir_req = 2'b00;
  logic        dir_load = 1'b0;
  logic [27:0] seg0, seg1;
  logic        go0, go1;
  logic [3:0]  len0, len1;

  snake_playfield #(.NUM_DIGITS(4), .TICK_DIV(4), .GROW_EVERY(4), .MAX_LEN(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .dir_req(dir_req), .dir_load(dir_load),
    .seg_n(seg0), .game_over(go0), .length(len0));

  snake_playfield #(.NUM_DIGITS(4), .TICK_DIV(4), .GROW_EVERY(1), .MAX_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dir_req(dir_req), .dir_load(dir_load),
    .seg_n(seg1), .game_over(go1), .length(len1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ntick = 0;
  bit armed = 1'b0;

  // Model: 0 idle, 1 running, 2 over
  int ge [2] = '{4, 1};
  int mx [2][16];
  int my [2][16];
  int mlen [2], mhead [2], mpend [2], mmoves [2], mst [2];
  bit mblank [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_init(input int k);
    for (int i = 0; i < 16; i++) begin
      mx[k][i] = 0;
      my[k][i] = 1;
    end
    mx[k][0] = 2; mx[k][1] = 1; mx[k][2] = 0;
    mlen[k] = 2; mhead[k] = 0; mpend[k] = 0; mmoves[k] = 0; mst[k] = 0; mblank[k] = 0;
  endtask

  task automatic m_step(input int k, input bit tk);
    int npend, nx, ny, lim;
    bit grw, hit;
    npend = mpend[k];
    if (mst[k] == 2) begin
      if (start) m_init(k);
      else if (tk) mblank[k] = !mblank[k];
      return;
    end
    if (dir_load && (int'(dir_req) != (mhead[k] + 2) % 4)) npend = int'(dir_req);
    if (mst[k] == 1 && tk) begin
      nx = mx[k][0] + ((mpend[k] == 0) ? 1 : (mpend[k] == 2) ? -1 : 0);
      ny = my[k][0] + ((mpend[k] == 3) ? 1 : (mpend[k] == 1) ? -1 : 0);
      grw = (mmoves[k] + 1 == ge[k]) && (mlen[k] < ML);
      hit = (nx < 0) || (nx > N) || (ny < 0) || (ny > 2);
      lim = mlen[k] + (grw ? 1 : 0);
      for (int i = 0; i < lim; i++)
        if (mx[k][i] == nx && my[k][i] == ny) hit = 1;
      if (hit) begin
        mst[k] = 2;
        mblank[k] = 0;
      end else begin
        for (int i = mlen[k] + 1; i >= 1; i--) begin
          mx[k][i] = mx[k][i-1];
          my[k][i] = my[k][i-1];
        end
        mx[k][0] = nx;
        my[k][0] = ny;
        if (grw) mlen[k]++;
        mmoves[k] = (mmoves[k] + 1 == ge[k]) ? 0 : mmoves[k] + 1;
      end
      mhead[k] = mpend[k];
    end else if (mst[k] == 0 && start) begin
      mst[k] = 1;
    end
    mpend[k] = npend;
  endtask

  function automatic logic [27:0] exp_seg(input int k);
    logic [27:0] s;
    int ax, ay, bx, by, c, t;
    s = '1;
    if (mblank[k]) return s;
    for (int i = 0; i < mlen[k]; i++) begin
      ax = mx[k][i]; ay = my[k][i]; bx = mx[k][i+1]; by = my[k][i+1];
      if (ay == by) begin
        c = (ax < bx) ? ax : bx;
        s[7*c + ((ay == 0) ? 0 : (ay == 1) ? 6 : 3)] = 1'b0;
      end else begin
        t = (ay < by) ? ay : by;
        if (ax < N) s[7*ax + ((t == 0) ? 5 : 4)] = 1'b0;
        if (ax > 0) s[7*(ax-1) + ((t == 0) ? 1 : 2)] = 1'b0;
      end
    end
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_init(0);
      m_init(1);
      cyc = 0;
    end else begin
      bit tk;
      tk = (cyc % TD == TD - 1);
      m_step(0, tk);
      m_step(1, tk);
      if (tk) ntick++;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("model seg0", {4'h0, seg0}, {4'h0, exp_seg(0)});
      chk("model go0", {31'd0, go0}, {31'd0, mst[0] == 2});
      chk("model len0", {28'd0, len0}, 32'(mlen[0]));
      chk("model seg1", {4'h0, seg1}, {4'h0, exp_seg(1)});
      chk("model go1", {31'd0, go1}, {31'd0, mst[1] == 2});
      chk("model len1", {28'd0, len1}, 32'(mlen[1]));
    end
  end

  // Stimulus tasks start and end just after a falling edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_dir(input logic [1:0] d);
    dir_req = d;
    dir_load = 1'b1;
    @(negedge clk);
    dir_load = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int target, guard;
    target = ntick + n;
    guard = 0;
    while (ntick < target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (ntick < target) begin
      checks++;
      errors++;
      $display("FAIL wait_ticks: got %0d ticks expected %0d", ntick, target);
    end
  endtask

  task automatic align_tick();
    while (cyc % TD != TD - 1) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] d);
    pulse_dir(d);
    wait_ticks(1);
  endtask

  initial begin
    @(negedge clk);

    // Idle after reset, unchanged across ten ticks
    do_reset();
    chk("rst seg0", {4'h0, seg0}, 32'h0FFFDFBF);
    chk("rst len0", {28'd0, len0}, 32'd2);
    chk("rst go0", {31'd0, go0}, 32'd0);
    wait_ticks(10);
    chk("idle seg0", {4'h0, seg0}, 32'h0FFFDFBF);
    chk("idle go1", {31'd0, go1}, 32'd0);

    // Straight run into the right wall
    pulse_start();
    wait_ticks(2);
    chk("run2 seg0", {4'h0, seg0}, 32'h07EFFFFF);
    wait_ticks(1);
    chk("wall go0", {31'd0, go0}, 32'd1);
    chk("wall len0", {28'd0, len0}, 32'd2);
    chk("wall seg0", {4'h0, seg0}, 32'h07EFFFFF);
    wait_ticks(1);
    chk("blink seg0", {4'h0, seg0}, 32'h0FFFFFFF);
    pulse_start();
    chk("restart seg0", {4'h0, seg0}, 32'h0FFFDFBF);
    chk("restart go0", {31'd0, go0}, 32'd0);

    // Start on a tick, reversal ignored, then turn up
    do_reset();
    align_tick();
    pulse_start();
    chk("start-on-tick seg0", {4'h0, seg0}, 32'h0FFFDFBF);
    pulse_dir(2'b10);
    wait_ticks(1);
    chk("reverse seg0", {4'h0, seg0}, 32'h0FEFDFFF);
    move(2'b01);
    chk("up seg0", {4'h0, seg0}, 32'h0BEF7FFF);

    // Every move grows (instance 1): up, left, down bites the body
    do_reset();
    pulse_start();
    move(2'b01);
    chk("grow len1", {28'd0, len1}, 32'd3);
    move(2'b10);
    chk("grow2 len1", {28'd0, len1}, 32'd4);
    move(2'b11);
    chk("bite go1", {31'd0, go1}, 32'd1);
    chk("bite len1", {28'd0, len1}, 32'd4);
    chk("bite seg1", {4'h0, seg1}, 32'h0FF7DE3F);
    chk("nobite go0", {31'd0, go0}, 32'd0);

    // Length saturation at MAX_LEN
    do_reset();
    pulse_start();
    wait_ticks(2);
    move(2'b01);
    move(2'b10);
    move(2'b10);
    move(2'b10);
    move(2'b10);
    move(2'b11);
    move(2'b11);
    chk("sat len1", {28'd0, len1}, 32'd8);
    chk("sat go1", {31'd0, go1}, 32'd0);
    chk("sat len0", {28'd0, len0}, 32'd4);

    // Asynchronous reset mid-run discards the pending turn
    do_reset();
    pulse_start();
    wait_ticks(1);
    pulse_dir(2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async seg0", {4'h0, seg0}, 32'h0FFFDFBF);
    chk("async go0", {31'd0, go0}, 32'd0);
    chk("async len1", {28'd0, len1}, 32'd2);
    #1 rst = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_ticks(1);
    chk("post-rst seg0", {4'h0, seg0}, 32'h0FEFDFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
